// File: rtl/mm_seq_pkg.sv
// Shared encodings and constants for the matrix-multiply sequencer.
// Imported by mm_seq_ctrl; the row loader is generic and does not need it.
package mm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_POST   = 3'd6,
        ST_CLEAR  = 3'd7
    } state_t;

    localparam logic [31:0] SP_CMD_OFS    = 32'h0000_0000;
    localparam logic [31:0] SP_STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] STATUS_DONE   = 32'h0000_0001;
    localparam logic [3:0]  BYTE_EN_ALL   = 4'hF;

endpackage

// File: rtl/bram_row_loader.sv
// Streams ROWS*WPR consecutive 32-bit words from a 1-cycle-latency BRAM and
// emits each assembled row as a one-cycle strobe; runs while start_i is held.
module bram_row_loader #(
    parameter int ROWS = 8,
    parameter int WPR  = 2,
    localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [31:0]          rd_data_i,
    output logic                 rd_en_o,
    output logic [31:0]          rd_addr_o,
    output logic [32*WPR-1:0]    row_data_o,
    output logic                 row_valid_o,
    output logic [IDXW-1:0]      row_idx_o,
    output logic                 done_o
);

    localparam int TOTAL = ROWS * WPR;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;

    logic [CW-1:0]          issueCnt_q;
    logic                   issuedAll_q;
    logic                   pend_q;
    logic [WW-1:0]          wordCnt_q;
    logic [IDXW-1:0]        rowCnt_q;
    logic [WPR-1:0][31:0]   rowBuf_q;
    logic [WPR-1:0][31:0]   merged;
    logic                   issuing;
    logic                   lastWord;

    assign issuing  = start_i & ~issuedAll_q;
    assign lastWord = pend_q && (wordCnt_q == WW'(WPR - 1));

    // Dropping start_i rewinds everything so the next phase starts at word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issueCnt_q  <= '0;
            issuedAll_q <= 1'b0;
            pend_q      <= 1'b0;
            wordCnt_q   <= '0;
            rowCnt_q    <= '0;
            rowBuf_q    <= '0;
        end else if (!start_i) begin
            issueCnt_q  <= '0;
            issuedAll_q <= 1'b0;
            pend_q      <= 1'b0;
            wordCnt_q   <= '0;
            rowCnt_q    <= '0;
        end else begin
            pend_q <= issuing;
            if (issuing) begin
                issueCnt_q <= issueCnt_q + 1'b1;
                if (issueCnt_q == CW'(TOTAL - 1)) begin
                    issuedAll_q <= 1'b1;
                end
            end
            if (pend_q) begin
                rowBuf_q[wordCnt_q] <= rd_data_i;
                if (lastWord) begin
                    wordCnt_q <= '0;
                    rowCnt_q  <= rowCnt_q + 1'b1;
                end else begin
                    wordCnt_q <= wordCnt_q + 1'b1;
                end
            end
        end
    end

    // The final word of a row is taken straight from the bus so the strobe
    // lands in the same cycle that word returns.
    always_comb begin
        merged          = rowBuf_q;
        merged[WPR-1]   = rd_data_i;
        row_data_o      = lastWord ? merged : '0;
    end

    assign row_valid_o = lastWord;
    assign row_idx_o   = lastWord ? rowCnt_q : '0;
    assign done_o      = lastWord && (rowCnt_q == IDXW'(ROWS - 1));
    assign rd_en_o     = issuing;
    assign rd_addr_o   = issuing ? (32'(issueCnt_q) << 2) : 32'd0;

endmodule

// File: rtl/mm_seq_ctrl.sv
// Top-level sequencer for the systolic matrix-multiply engine: polls the host
// command word, loads A/W tiles, runs the array, drains results, posts status.
module mm_seq_ctrl
    import mm_seq_pkg::*;
#(
    parameter int ARRAY_N   = 8,
    parameter int ARRAY_M   = 8,
    parameter int ACT_WIDTH = 8,
    parameter int WGT_WIDTH = 8,
    parameter int OUT_WIDTH = 32,
    parameter int WPR       = ARRAY_N * ACT_WIDTH / 32
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [31:0]                       addr_sp_bram,
    output logic                              enable_sp_bram,
    input  logic [31:0]                       data_out_sp_bram,
    output logic [3:0]                        w_enable_sp_bram,
    output logic [31:0]                       data_in_sp_bram,
    output logic [31:0]                       addr_a_bram,
    output logic                              enable_a_bram,
    input  logic [31:0]                       data_out_a_bram,
    output logic [31:0]                       addr_w_bram,
    output logic                              enable_w_bram,
    input  logic [31:0]                       data_out_w_bram,
    output logic [31:0]                       addr_o_bram,
    output logic                              enable_o_bram,
    output logic [3:0]                        w_enable_o_bram,
    output logic [31:0]                       data_in_o_bram,
    output logic [ARRAY_N*ACT_WIDTH-1:0]      act_row_data,
    output logic                              act_row_valid,
    output logic [$clog2(ARRAY_N)-1:0]        act_row_idx,
    output logic [ARRAY_M*WGT_WIDTH-1:0]      wgt_row_data,
    output logic                              wgt_row_valid,
    output logic [$clog2(ARRAY_M)-1:0]        wgt_row_idx,
    output logic                              compute_start,
    input  logic                              compute_done,
    output logic                              res_rd_en,
    output logic [$clog2(ARRAY_N*ARRAY_M)-1:0] res_rd_idx,
    input  logic [OUT_WIDTH-1:0]              res_rd_data,
    output logic                              busy,
    output logic [5:0]                        DEBUG_state
);

    localparam int NM    = ARRAY_N * ARRAY_M;
    localparam int DW    = $clog2(NM + 1);
    localparam int RIW   = $clog2(NM);
    localparam int WPR_W = ARRAY_M * WGT_WIDTH / 32;

    state_t          state_q, state_d;
    logic            live_q;
    logic            spValid_q;
    logic            spStart_q;
    logic [DW-1:0]   drainCnt_q;
    logic            wrPend_q;
    logic [RIW-1:0]  wrIdx_q;
    logic            doneA, doneW;
    logic            unusedSpBits;

    assign unusedSpBits = ^data_out_sp_bram[31:1];

    bram_row_loader #(.ROWS(ARRAY_N), .WPR(WPR)) u_load_a (
        .clk(clk), .reset(reset), .start_i(state_q == ST_LOAD_A),
        .rd_data_i(data_out_a_bram), .rd_en_o(enable_a_bram), .rd_addr_o(addr_a_bram),
        .row_data_o(act_row_data), .row_valid_o(act_row_valid),
        .row_idx_o(act_row_idx), .done_o(doneA)
    );

    bram_row_loader #(.ROWS(ARRAY_M), .WPR(WPR_W)) u_load_w (
        .clk(clk), .reset(reset), .start_i(state_q == ST_LOAD_W),
        .rd_data_i(data_out_w_bram), .rd_en_o(enable_w_bram), .rd_addr_o(addr_w_bram),
        .row_data_o(wgt_row_data), .row_valid_o(wgt_row_valid),
        .row_idx_o(wgt_row_idx), .done_o(doneW)
    );

    // spValid_q marks poll data that came from a genuine IDLE read, so the
    // read-first word returned by the CLEAR write is never mistaken for a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            live_q     <= 1'b0;
            spValid_q  <= 1'b0;
            spStart_q  <= 1'b0;
            drainCnt_q <= '0;
            wrPend_q   <= 1'b0;
            wrIdx_q    <= '0;
        end else begin
            state_q    <= state_d;
            live_q     <= 1'b1;
            spValid_q  <= (state_q == ST_IDLE) && live_q;
            spStart_q  <= (state_q == ST_IDLE) && spValid_q && data_out_sp_bram[0];
            drainCnt_q <= (state_q == ST_DRAIN) ? drainCnt_q + 1'b1 : '0;
            wrPend_q   <= res_rd_en;
            wrIdx_q    <= res_rd_idx;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_sp_bram     = 32'd0;
        enable_sp_bram   = 1'b0;
        w_enable_sp_bram = 4'h0;
        data_in_sp_bram  = 32'd0;
        addr_o_bram      = 32'd0;
        enable_o_bram    = 1'b0;
        w_enable_o_bram  = 4'h0;
        data_in_o_bram   = 32'd0;
        compute_start    = 1'b0;
        res_rd_en        = 1'b0;
        res_rd_idx       = '0;
        case (state_q)
            ST_IDLE: begin
                addr_sp_bram   = SP_CMD_OFS;
                enable_sp_bram = live_q;
                if (spStart_q) state_d = ST_LOAD_A;
            end
            ST_LOAD_A: if (doneA) state_d = ST_LOAD_W;
            ST_LOAD_W: if (doneW) state_d = ST_START;
            ST_START: begin
                compute_start = 1'b1;
                state_d       = ST_WAIT;
            end
            ST_WAIT: if (compute_done) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (drainCnt_q < DW'(NM)) begin
                    res_rd_en  = 1'b1;
                    res_rd_idx = drainCnt_q[RIW-1:0];
                end
                if (wrPend_q) begin
                    enable_o_bram   = 1'b1;
                    w_enable_o_bram = BYTE_EN_ALL;
                    addr_o_bram     = 32'(wrIdx_q) << 2;
                    data_in_o_bram  = res_rd_data;
                end
                if (drainCnt_q == DW'(NM)) state_d = ST_POST;
            end
            ST_POST: begin
                addr_sp_bram     = SP_STATUS_OFS;
                enable_sp_bram   = 1'b1;
                w_enable_sp_bram = BYTE_EN_ALL;
                data_in_sp_bram  = STATUS_DONE;
                state_d          = ST_CLEAR;
            end
            ST_CLEAR: begin
                addr_sp_bram     = SP_CMD_OFS;
                enable_sp_bram   = 1'b1;
                w_enable_sp_bram = BYTE_EN_ALL;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign DEBUG_state = {3'b000, state_q};

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Scoreboard bench for mm_seq_ctrl: BRAM/array models, a queue-based reference
// of every row strobe and BRAM write, and a negedge monitor that pops and compares.
module tb_mm_seq_ctrl;

    localparam int N   = 8;
    localparam int M   = 8;
    localparam int WPR = 2;
    localparam int NM  = N * M;

    typedef struct packed {
        logic [2:0]  idx;
        logic [63:0] data;
    } rowExp_t;

    logic        clk;
    logic        reset;
    logic [31:0] addr_sp_bram, data_out_sp_bram, data_in_sp_bram;
    logic        enable_sp_bram;
    logic [3:0]  w_enable_sp_bram;
    logic [31:0] addr_a_bram, data_out_a_bram, addr_w_bram, data_out_w_bram;
    logic        enable_a_bram, enable_w_bram;
    logic [31:0] addr_o_bram, data_in_o_bram;
    logic        enable_o_bram;
    logic [3:0]  w_enable_o_bram;
    logic [63:0] act_row_data, wgt_row_data;
    logic        act_row_valid, wgt_row_valid;
    logic [2:0]  act_row_idx, wgt_row_idx;
    logic        compute_start, compute_done;
    logic        res_rd_en;
    logic [5:0]  res_rd_idx;
    logic [31:0] res_rd_data;
    logic        busy;
    logic [5:0]  DEBUG_state;

    logic [31:0] spMem [0:1];
    logic [31:0] aMem  [0:15];
    logic [31:0] wMem  [0:15];
    logic [31:0] resMem[0:NM-1];
    logic        hostArm;

    rowExp_t     expAct[$];
    rowExp_t     expWgt[$];
    logic [63:0] expO[$];
    logic [63:0] expSp[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lastAct = 0;
    int lastWgt = 0;
    int startCnt = 0;
    int oCnt = 0;
    rowExp_t e;
    logic [63:0] ew;

    mm_seq_ctrl dut (
        .clk(clk), .reset(reset),
        .addr_sp_bram(addr_sp_bram), .enable_sp_bram(enable_sp_bram),
        .data_out_sp_bram(data_out_sp_bram), .w_enable_sp_bram(w_enable_sp_bram),
        .data_in_sp_bram(data_in_sp_bram),
        .addr_a_bram(addr_a_bram), .enable_a_bram(enable_a_bram), .data_out_a_bram(data_out_a_bram),
        .addr_w_bram(addr_w_bram), .enable_w_bram(enable_w_bram), .data_out_w_bram(data_out_w_bram),
        .addr_o_bram(addr_o_bram), .enable_o_bram(enable_o_bram),
        .w_enable_o_bram(w_enable_o_bram), .data_in_o_bram(data_in_o_bram),
        .act_row_data(act_row_data), .act_row_valid(act_row_valid), .act_row_idx(act_row_idx),
        .wgt_row_data(wgt_row_data), .wgt_row_valid(wgt_row_valid), .wgt_row_idx(wgt_row_idx),
        .compute_start(compute_start), .compute_done(compute_done),
        .res_rd_en(res_rd_en), .res_rd_idx(res_rd_idx), .res_rd_data(res_rd_data),
        .busy(busy), .DEBUG_state(DEBUG_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAMs with 1-cycle latency; the host side only arms the command word.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (enable_sp_bram) begin
            data_out_sp_bram <= spMem[addr_sp_bram[2]];
            if (w_enable_sp_bram == 4'hF) spMem[addr_sp_bram[2]] <= data_in_sp_bram;
        end
        if (hostArm) begin
            spMem[0] <= 32'd1;
            spMem[1] <= 32'd0;
        end
        if (enable_a_bram) data_out_a_bram <= aMem[addr_a_bram[5:2]];
        if (enable_w_bram) data_out_w_bram <= wMem[addr_w_bram[5:2]];
        if (res_rd_en) res_rd_data <= resMem[res_rd_idx];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkZero(input string name);
        logic anyOut;
        anyOut = |{addr_sp_bram, enable_sp_bram, w_enable_sp_bram, data_in_sp_bram,
                   addr_a_bram, enable_a_bram, addr_w_bram, enable_w_bram,
                   addr_o_bram, enable_o_bram, w_enable_o_bram, data_in_o_bram,
                   act_row_data, act_row_valid, act_row_idx,
                   wgt_row_data, wgt_row_valid, wgt_row_idx,
                   compute_start, res_rd_en, res_rd_idx, busy, DEBUG_state};
        checkOutput(name, 64'(anyOut), 64'd0);
    endtask

    // Reference model: row r is words r*WPR..r*WPR+WPR-1 with word 0 in the LSBs;
    // the drain writes result i to byte address 4*i; then status, then command clear.
    task automatic applyStimulus(input bit pattern, input bit newData);
        rowExp_t r;
        if (newData) begin
            for (int k = 0; k < 16; k++) begin
                aMem[k] = pattern ? 32'h03020100 + 32'(32'h04040404 * k) : $urandom;
                wMem[k] = pattern ? 32'h03020100 + 32'(32'h04040404 * k) : $urandom;
            end
            for (int i = 0; i < NM; i++) resMem[i] = pattern ? 32'(1000 + i) : $urandom;
        end
        for (int row = 0; row < N; row++) begin
            r.idx = 3'(row);
            for (int j = 0; j < WPR; j++) r.data[32*j +: 32] = aMem[row*WPR + j];
            expAct.push_back(r);
            for (int j = 0; j < WPR; j++) r.data[32*j +: 32] = wMem[row*WPR + j];
            expWgt.push_back(r);
        end
        for (int i = 0; i < NM; i++) expO.push_back({32'(4 * i), resMem[i]});
        expSp.push_back({32'd4, 32'd1});
        expSp.push_back({32'd0, 32'd0});
    endtask

    task automatic armHost();
        hostArm = 1'b1;
        @(posedge clk);
        #1 hostArm = 1'b0;
    endtask

    task automatic waitState(input logic [5:0] st, input int maxCyc, input string name);
        int n = 0;
        while (DEBUG_state !== st && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(DEBUG_state), 64'(st));
    endtask

    task automatic runBody(input int abortAt);
        int sBase = startCnt;
        int oBase = oCnt;
        int n = 0;
        waitState(6'd2, 200, "reach_load_w");
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        waitState(6'd3, 100, "reach_start");
        repeat (19) @(negedge clk);
        checkOutput("wait_holds", 64'(DEBUG_state), 64'd4);
        @(negedge clk);
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        checkOutput("drain_entry", 64'(DEBUG_state), 64'd5);
        checkOutput("drain_first_rd", 64'({res_rd_en, res_rd_idx}), 64'({1'b1, 6'd0}));
        if (abortAt >= 0) begin
            while (!(res_rd_en && res_rd_idx == 6'(abortAt)) && n < NM + 4) begin
                @(negedge clk);
                n++;
            end
            checkOutput("abort_point", 64'(res_rd_idx), 64'(abortAt));
            #2 reset = 1'b1;
            #1 checkZero("abort_outputs");
            checkOutput("abort_sp_cmd", 64'(spMem[0]), 64'd1);
            checkOutput("abort_sp_status", 64'(spMem[1]), 64'd0);
            expAct.delete();
            expWgt.delete();
            expO.delete();
            expSp.delete();
            return;
        end
        waitState(6'd0, 200, "run_end");
        checkOutput("act_rows_left", 64'(expAct.size()), 64'd0);
        checkOutput("wgt_rows_left", 64'(expWgt.size()), 64'd0);
        checkOutput("o_writes_left", 64'(expO.size()), 64'd0);
        checkOutput("sp_writes_left", 64'(expSp.size()), 64'd0);
        checkOutput("start_pulses", 64'(startCnt - sBase), 64'd1);
        checkOutput("o_write_count", 64'(oCnt - oBase), 64'(NM));
        checkOutput("sp_cmd_cleared", 64'(spMem[0]), 64'd0);
        checkOutput("sp_status_done", 64'(spMem[1]), 64'd1);
    endtask

    // Monitor: every strobe or BRAM write the DUT presents is matched against the queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (act_row_valid) begin
                if (expAct.size() == 0) checkOutput("act_extra", 64'd1, 64'd0);
                else begin
                    e = expAct.pop_front();
                    checkOutput("act_data", act_row_data, e.data);
                    checkOutput("act_idx", 64'(act_row_idx), 64'(e.idx));
                    if (act_row_idx != 3'd0) checkOutput("act_spacing", 64'(cyc - lastAct), 64'(WPR));
                    lastAct = cyc;
                end
            end
            if (wgt_row_valid) begin
                if (expWgt.size() == 0) checkOutput("wgt_extra", 64'd1, 64'd0);
                else begin
                    e = expWgt.pop_front();
                    checkOutput("wgt_data", wgt_row_data, e.data);
                    checkOutput("wgt_idx", 64'(wgt_row_idx), 64'(e.idx));
                    if (wgt_row_idx != 3'd0) checkOutput("wgt_spacing", 64'(cyc - lastWgt), 64'(WPR));
                    lastWgt = cyc;
                end
            end
            if (enable_o_bram) begin
                oCnt++;
                checkOutput("o_wen", 64'(w_enable_o_bram), 64'hF);
                if (expO.size() == 0) checkOutput("o_extra", 64'd1, 64'd0);
                else begin
                    ew = expO.pop_front();
                    checkOutput("o_write", {addr_o_bram, data_in_o_bram}, ew);
                end
            end
            if (w_enable_sp_bram != 4'h0) begin
                checkOutput("sp_wen", 64'({enable_sp_bram, w_enable_sp_bram}), 64'h1F);
                if (expSp.size() == 0) checkOutput("sp_extra", 64'd1, 64'd0);
                else begin
                    ew = expSp.pop_front();
                    checkOutput("sp_write", {addr_sp_bram, data_in_sp_bram}, ew);
                end
            end
            if (compute_start) startCnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        compute_done = 1'b0;
        hostArm = 1'b0;
        spMem[0] = 32'd0;
        spMem[1] = 32'd0;
        data_out_sp_bram = 32'd0;
        data_out_a_bram = 32'd0;
        data_out_w_bram = 32'd0;
        res_rd_data = 32'd0;
        repeat (3) @(negedge clk);
        checkZero("reset_outputs");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("idle_no_start", 64'({busy, DEBUG_state}), 64'd0);

        // Run 1: spec pattern data, poll-to-load latency
        applyStimulus(1'b1, 1'b1);
        armHost();
        n = 0;
        while (data_out_sp_bram[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("poll_data_seen", 64'(data_out_sp_bram[0]), 64'd1);
        @(negedge clk);
        checkOutput("poll_lat1", 64'(DEBUG_state), 64'd0);
        @(negedge clk);
        checkOutput("poll_lat2", 64'(DEBUG_state), 64'd1);
        checkOutput("busy_load", 64'(busy), 64'd1);
        runBody(-1);

        // Run 2: random data, aborted by reset at result 30, then relaunched by the pending start
        applyStimulus(1'b0, 1'b1);
        armHost();
        runBody(30);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        runBody(-1);

        // Run 3: host re-arms right after the clear; same data must be rewritten
        applyStimulus(1'b0, 1'b0);
        armHost();
        runBody(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
